sha1_msg_schedule: RTL and testbench

SHA1_MSG_SCHEDULE -- requirements
Module: sha1_msg_schedule

---
 rtl/sha1_msg_schedule_if.sv | 23 ++
 rtl/sha1_msg_schedule.sv | 78 +++++++
 tb/tb_sha1_msg_schedule.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_msg_schedule_if.sv
// Handshake bundle between the message source, the SHA-1 schedule block and the round core.
// The master side is the message source / round core; the slave side is the schedule block.
interface sha1_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [6:0]  out_t;
  logic        out_last;
  logic        busy;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_t, out_last, busy
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_t, out_last, busy
  );
endinterface

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: loads 16 words M0..M15, then streams W[0..79] to the round core
// using a 16-entry circular buffer that is overwritten in place as new words are produced.
module sha1_msg_schedule (
  input logic                clk,
  input logic                rst,
  sha1_msg_schedule_if.slave sched_io
);

  typedef enum logic {StLoad, StEmit} state_e;

  state_e      state_q;
  logic [3:0]  ld_cnt_q;
  logic [6:0]  t_q;
  logic [31:0] buf_q [16];

  logic [3:0]  idx, idx_m3, idx_m8, idx_m14;
  logic [31:0] mix, w_new, w_cur;
  logic        in_xfer, out_xfer;

  always_comb begin
    idx     = t_q[3:0];
    // Slot (t-16) mod 16 is the slot of t itself, so it is read before being overwritten.
    idx_m3  = idx - 4'd3;
    idx_m8  = idx - 4'd8;
    idx_m14 = idx - 4'd14;
    mix     = buf_q[idx_m3] ^ buf_q[idx_m8] ^ buf_q[idx_m14] ^ buf_q[idx];
    w_new   = {mix[30:0], mix[31]};
    w_cur   = (t_q < 7'd16) ? buf_q[idx] : w_new;
    in_xfer  = sched_io.in_valid && (state_q == StLoad);
    out_xfer = sched_io.out_ready && (state_q == StEmit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      ld_cnt_q <= 4'd0;
      t_q      <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 32'h0;
      end
    end else begin
      case (state_q)
        StLoad: begin
          if (in_xfer) begin
            buf_q[ld_cnt_q] <= sched_io.in_word;
            ld_cnt_q        <= ld_cnt_q + 4'd1;
            if (ld_cnt_q == 4'd15) begin
              state_q <= StEmit;
              t_q     <= 7'd0;
            end
          end
        end
        StEmit: begin
          if (out_xfer) begin
            if (t_q >= 7'd16) begin
              buf_q[idx] <= w_new;
            end
            if (t_q == 7'd79) begin
              state_q <= StLoad;
              t_q     <= 7'd0;
            end else begin
              t_q <= t_q + 7'd1;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign sched_io.in_ready  = (state_q == StLoad);
  assign sched_io.out_valid = (state_q == StEmit);
  assign sched_io.out_word  = w_cur;
  assign sched_io.out_t     = t_q;
  assign sched_io.out_last  = (state_q == StEmit) && (t_q == 7'd79);
  assign sched_io.busy      = (state_q == StEmit);

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// Bench for sha1_msg_schedule: hand-computed "abc" vectors, a straight-array golden schedule,
// stalls, ignored input during emit, reset aborts and back-to-back blocks with random gaps.
module tb_sha1_msg_schedule;

  typedef struct packed {
    logic [6:0]  t;
    logic [31:0] w;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sha1_msg_schedule_if bus ();

  sha1_msg_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .sched_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic golden(input logic [31:0] m [16], output logic [31:0] w [80]);
    logic [31:0] x;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 80; t++) begin
      x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {x[30:0], x[31]};
    end
  endtask

  // Called at a negedge; feeds n words, returns at a negedge.
  task automatic load(input logic [31:0] m [16], input bit gaps, input int n);
    int i   = 0;
    int cyc = 0;
    check("load out_valid low", {31'd0, bus.out_valid}, 32'd0);
    while (i < n && cyc < 1000) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_word  = bus.in_valid ? m[i] : $urandom;
      if (bus.in_valid && bus.in_ready) i++;
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("load count", i, n);
    if (n == 16) check("first out_valid latency", {31'd0, bus.out_valid}, 32'd1);
  endtask

  // Called at a negedge; mode 0 = always ready, 1 = random ready, 2 = 5-cycle stall at t=20.
  task automatic collect(input int mode, input bit poke_in, input int n_xfer,
                         output logic [31:0] w [80], output int busy_cycles);
    int          k = 0;
    int          cyc = 0;
    int          stall = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] pw = '0;
    logic [6:0]  pt = '0;
    busy_cycles = 0;
    for (int i = 0; i < 80; i++) w[i] = 'x;
    while (k < n_xfer && cyc < 3000) begin
      case (mode)
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (bus.out_t == 7'd20 && stall < 5) begin
            bus.out_ready = 1'b0;
            stall++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
      if (poke_in) begin
        bus.in_valid = 1'b1;
        bus.in_word  = $urandom;
        check("in_ready low in emit", {31'd0, bus.in_ready}, 32'd0);
      end
      if (prev_stall) begin
        check("stall word stable", bus.out_word, pw);
        check("stall t stable", {25'd0, bus.out_t}, {25'd0, pt});
      end
      if (bus.busy) busy_cycles++;
      if (bus.out_valid && bus.out_ready) begin
        check("out_t", {25'd0, bus.out_t}, k);
        check("out_last", {31'd0, bus.out_last}, {31'd0, (k == 79)});
        w[k] = bus.out_word;
        k++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      pw = bus.out_word;
      pt = bus.out_t;
      cyc++;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("collect count", k, n_xfer);
  endtask

  task automatic compare(input string name, input logic [31:0] m [16]);
    logic [31:0] g [80];
    golden(m, g);
    check({name, " ready for next block"}, {31'd0, bus.in_ready}, 32'd1);
    check({name, " t back to 0"}, {25'd0, bus.out_t}, 32'd0);
  endtask

  task automatic cmp_words(input string name, input logic [31:0] m [16],
                           input logic [31:0] w [80]);
    logic [31:0] g [80];
    int          bad = 0;
    golden(m, g);
    for (int t = 0; t < 80; t++) begin
      if (w[t] !== g[t]) begin
        bad++;
        if (bad <= 4) $display("FAIL %s W[%0d]: got %08h required %08h", name, t, w[t], g[t]);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

  task automatic reset_checks(input string name);
    check({name, " in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({name, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, " out_word"},  bus.out_word,            32'd0);
    check({name, " out_t"},     {25'd0, bus.out_t},      32'd0);
    check({name, " out_last"},  {31'd0, bus.out_last},  32'd0);
    check({name, " busy"},      {31'd0, bus.busy},      32'd0);
  endtask

  initial begin
    logic [31:0] abc [16];
    logic [31:0] zero [16];
    logic [31:0] ra [16];
    logic [31:0] rb [16];
    logic [31:0] w [80];
    int          bc;
    vec_t        abc_vec [9];

    abc_vec = '{
      '{7'd0,  32'h61626380}, '{7'd1,  32'h00000000}, '{7'd15, 32'h00000018},
      '{7'd16, 32'hC2C4C700}, '{7'd17, 32'h00000000}, '{7'd18, 32'h00000030},
      '{7'd19, 32'h85898E01}, '{7'd20, 32'h00000000}, '{7'd21, 32'h00000060}
    };
    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'h0;
      zero[i] = 32'h0;
      ra[i]   = $urandom;
      rb[i]   = $urandom;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    bus.in_valid  = 1'b1;
    bus.in_word   = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // "abc" block, table of hand-computed words
    load(abc, 1'b0, 16);
    collect(0, 1'b0, 80, w, bc);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("abc W%0d", abc_vec[i].t), w[abc_vec[i].t], abc_vec[i].w);
    end
    cmp_words("abc", abc, w);
    compare("abc", abc);

    // all-zero block, busy for exactly 80 cycles
    load(zero, 1'b0, 16);
    collect(0, 1'b0, 80, w, bc);
    check("zero busy cycles", bc, 80);
    check("zero W79", w[79], 32'h0);
    cmp_words("zero", zero, w);
    check("busy low after block", {31'd0, bus.busy}, 32'd0);

    // stall at t=20 with in_valid poking during emit
    load(ra, 1'b0, 16);
    collect(2, 1'b1, 80, w, bc);
    cmp_words("stall", ra, w);
    compare("stall", ra);

    // reset at t=40, then reset mid-load, then a clean block
    load(rb, 1'b0, 16);
    collect(0, 1'b0, 40, w, bc);
    check("abort at t40", {25'd0, bus.out_t}, 32'd40);
    rst = 1'b1;
    #1;
    reset_checks("emit abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(ra, 1'b0, 7);
    rst = 1'b1;
    #1;
    reset_checks("load abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(rb, 1'b1, 16);
    collect(1, 1'b0, 80, w, bc);
    cmp_words("after reset", rb, w);

    // back-to-back blocks with random gaps
    load(ra, 1'b1, 16);
    collect(1, 1'b0, 80, w, bc);
    cmp_words("b2b A", ra, w);
    compare("b2b A", ra);
    load(abc, 1'b1, 16);
    collect(1, 1'b0, 80, w, bc);
    cmp_words("b2b B", abc, w);
    compare("b2b B", abc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
